reg_view_sel: RTL and testbench

Display-source stage feeding the 8-digit seven-segment scanner. It debounces two push-buttons (next/previous) to step a register index through 0..31. It reads the selected register through a read port of the CPU register file on a periodic refresh, or immediately after a step, and holds the captured word on a 32-bit output. The scanner consumes that output as its display data. Optionally the index is overlaid on the top byte so the operator sees which register is shown.

---
 rtl/reg_view_sel_pkg.sv | 19 +
 rtl/reg_view_sel_if.sv | 28 ++
 rtl/reg_view_sel_btn_debounce.sv | 56 +++++
 rtl/reg_view_sel.sv | 133 +++++++++++++
 tb/tb_reg_view_sel.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/reg_view_sel_pkg.sv
// Shared definitions for the register-view display source.
//   IDX_W / DATA_W : register index and data widths
//   rd_state_e     : read FSM states
//   cnt_w()        : counter width needed to count 0..n-1 (at least 1 bit)
package reg_view_sel_pkg;

  localparam int unsigned IDX_W  = 5;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [0:0] {
    IDLE,
    WAIT
  } rd_state_e;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_view_sel_if.sv
// Register-file read port plus display outputs of reg_view_sel.
//   rf_raddr  : read address to the register file
//   rf_rdata  : read data from the register file
//   disp_data : word to the seven-segment scanner
//   cur_idx   : currently selected register index
// master = reg_view_sel side, slave = register file / scanner side.
interface reg_view_sel_if;
  import reg_view_sel_pkg::*;

  logic [IDX_W-1:0]  rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic [DATA_W-1:0] disp_data;
  logic [IDX_W-1:0]  cur_idx;

  modport master (
    output rf_raddr,
    input  rf_rdata,
    output disp_data,
    output cur_idx
  );

  modport slave (
    input  rf_raddr,
    output rf_rdata,
    input  disp_data,
    input  cur_idx
  );
endinterface

// File: rtl/reg_view_sel_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, debounce counter and a
// registered one-cycle pulse on each debounced press (release is silent).
//   clk, rst : clock, synchronous active-high reset
//   raw      : asynchronous bouncing button, high = pressed
//   pulse    : one-cycle step pulse per accepted press
module btn_debounce
  import reg_view_sel_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int unsigned CntW = cnt_w(DEB_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'((DEB_CYCLES == 0) ? 0 : DEB_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            deb_q, deb_d;
  logic            pulse_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronised level disagrees; any agreement clears it.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CntLast) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      pulse_q <= deb_d & ~deb_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/reg_view_sel.sv
// Display-source stage for the seven-segment scanner. Two debounced buttons step a
// register index 0..31; the selected register is read through the register-file
// port after each step, periodically, and once after reset, and held for display.
//   clk, rst           : clock, synchronous active-high reset
//   btn_next, btn_prev : raw push-buttons
//   show_idx           : overlay the index onto the top byte of the display word
//   bus (master)       : rf_raddr/rf_rdata read port, disp_data, cur_idx
module reg_view_sel
  import reg_view_sel_pkg::*;
#(
  parameter int unsigned DEB_CYCLES     = 1_000_000,
  parameter int unsigned REFRESH_CYCLES = 1_000_000,
  parameter int unsigned RD_LAT         = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           btn_next,
  input  logic           btn_prev,
  input  logic           show_idx,
  reg_view_sel_if.master bus
);

  localparam int unsigned RefW = cnt_w(REFRESH_CYCLES);
  localparam logic [RefW-1:0] RefLast =
      RefW'((REFRESH_CYCLES == 0) ? 0 : REFRESH_CYCLES - 1);
  localparam int unsigned WcW = cnt_w(RD_LAT + 1);
  localparam logic [WcW-1:0] RdLat = WcW'(RD_LAT);

  logic step_next, step_prev;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_next),
    .pulse (step_next)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_prev (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_prev),
    .pulse (step_prev)
  );

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              chg_q, chg_d;
  logic [RefW-1:0]   ref_q, ref_d;
  logic              ref_tick;
  logic              pend_q, pend_d;
  logic              req;
  rd_state_e         state_q, state_d;
  logic [IDX_W-1:0]  raddr_q, raddr_d;
  logic [WcW-1:0]    wcnt_q, wcnt_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  // Index stepping; simultaneous next+prev cancels and raises no read.
  always_comb begin
    idx_d = idx_q;
    chg_d = step_next ^ step_prev;
    if (step_next && !step_prev) idx_d = idx_q + 1'b1;
    if (step_prev && !step_next) idx_d = idx_q - 1'b1;
  end

  assign ref_tick = (ref_q == RefLast);
  assign ref_d    = ref_tick ? '0 : ref_q + 1'b1;
  assign req      = chg_q | ref_tick | pend_q;

  // Read FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req) state_d = WAIT;
      WAIT: if (!chg_q && wcnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read FSM: datapath actions. An index change in WAIT restarts the read so a
  // word fetched for a stale index is never captured; refresh ticks in WAIT are dropped.
  always_comb begin
    raddr_d = raddr_q;
    wcnt_d  = wcnt_q;
    hold_d  = hold_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          raddr_d = idx_q;
          wcnt_d  = RdLat;
          pend_d  = 1'b0;
        end
      end
      WAIT: begin
        if (chg_q) begin
          raddr_d = idx_q;
          wcnt_d  = RdLat;
        end else if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - 1'b1;
        end else begin
          hold_d = bus.rf_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      chg_q   <= 1'b0;
      ref_q   <= '0;
      pend_q  <= 1'b1;
      raddr_q <= '0;
      wcnt_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      chg_q   <= chg_d;
      ref_q   <= ref_d;
      pend_q  <= pend_d;
      raddr_q <= raddr_d;
      wcnt_q  <= wcnt_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.rf_raddr  = raddr_q;
  assign bus.cur_idx   = idx_q;
  assign bus.disp_data = show_idx ? {3'b000, idx_q, hold_q[23:0]} : hold_q;

endmodule

// File: tb/tb_reg_view_sel.sv
module tb_reg_view_sel;

  logic clk = 1'b0;
  logic rst;
  logic btn_next, btn_prev, show_idx;

  reg_view_sel_if bus ();

  reg_view_sel #(
    .DEB_CYCLES     (4),
    .REFRESH_CYCLES (16),
    .RD_LAT         (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_next (btn_next),
    .btn_prev (btn_prev),
    .show_idx (show_idx),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Register-file model with one edge of read latency.
  logic [31:0] mem [32];
  logic [31:0] rdata_q;
  always @(posedge clk) rdata_q <= mem[bus.rf_raddr];
  assign bus.rf_rdata = rdata_q;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_disp[$];
  logic [4:0]  exp_idx[$];
  logic [31:0] last_disp;
  logic [4:0]  last_idx;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Pops an expectation on every change of disp_data / cur_idx.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (bus.disp_data !== last_disp) begin
        last_disp = bus.disp_data;
        if (exp_disp.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL disp_unexpected: got %h, want no change", last_disp);
        end else begin
          check("disp_data", last_disp, exp_disp.pop_front());
        end
      end
      if (bus.cur_idx !== last_idx) begin
        last_idx = bus.cur_idx;
        if (exp_idx.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL idx_unexpected: got %0d, want no change", last_idx);
        end else begin
          check("cur_idx", {27'd0, last_idx}, {27'd0, exp_idx.pop_front()});
        end
      end
    end
  endtask

  task automatic drain(input string name, input int max_cycles);
    int k = 0;
    while ((exp_disp.size() != 0 || exp_idx.size() != 0) && k < max_cycles) begin
      tick();
      k++;
    end
    check(name, exp_disp.size() + exp_idx.size(), 0);
  endtask

  task automatic press(input logic nxt, input logic prv);
    btn_next = nxt;
    btn_prev = prv;
    repeat (12) tick();
    btn_next = 1'b0;
    btn_prev = 1'b0;
    repeat (8) tick();
  endtask

  task automatic step(input logic nxt, input logic [4:0] new_idx);
    exp_idx.push_back(new_idx);
    exp_disp.push_back(32'hA000_0000 + {27'd0, new_idx});
    press(nxt, ~nxt);
    drain("step", 20);
  endtask

  initial begin
    logic bad;
    logic found;
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + i;
    rst = 1'b1;
    btn_next = 1'b0;
    btn_prev = 1'b0;
    show_idx = 1'b0;
    repeat (3) tick();
    check("reset_disp", bus.disp_data, 32'h0);
    check("reset_raddr", {27'd0, bus.rf_raddr}, 32'h0);
    check("reset_idx", {27'd0, bus.cur_idx}, 32'h0);
    last_disp = 32'h0;
    last_idx  = 5'd0;
    fork monitor(); join_none

    // Pending read of register 0 right after reset release.
    exp_disp.push_back(32'hA000_0000);
    rst = 1'b0;
    tick();
    check("post_rst_raddr", {27'd0, bus.rf_raddr}, 32'h0);
    check("post_rst_disp_e0", bus.disp_data, 32'h0);
    tick();
    check("post_rst_disp_e1", bus.disp_data, 32'h0);
    tick();
    check("post_rst_disp_e2", bus.disp_data, 32'hA000_0000);
    drain("post_rst", 5);
    repeat (20) tick();

    // Bouncing press followed by a long hold: exactly one step.
    exp_idx.push_back(5'd1);
    exp_disp.push_back(32'hA000_0001);
    for (int i = 0; i < 2; i++) begin
      btn_next = 1'b1;
      repeat (2) tick();
      btn_next = 1'b0;
      repeat (2) tick();
    end
    btn_next = 1'b1;
    repeat (20) tick();
    btn_next = 1'b0;
    repeat (10) tick();
    drain("bounce", 5);
    check("bounce_idx", {27'd0, bus.cur_idx}, 32'd1);

    // Wrap in both directions.
    step(1'b0, 5'd0);
    step(1'b0, 5'd31);
    check("wrap_down_disp", bus.disp_data, 32'hA000_001F);
    step(1'b1, 5'd0);

    // Both buttons together: no step and no new read address.
    bad = 1'b0;
    btn_next = 1'b1;
    btn_prev = 1'b1;
    for (int i = 0; i < 28; i++) begin
      if (i == 12) begin
        btn_next = 1'b0;
        btn_prev = 1'b0;
      end
      tick();
      if (bus.rf_raddr != 5'd0) bad = 1'b1;
    end
    check("both_raddr_moved", {31'd0, bad}, 32'd0);
    check("both_idx", {27'd0, bus.cur_idx}, 32'd0);

    for (int i = 1; i <= 5; i++) step(1'b1, 5'(i));

    // Refresh picks up a changed register value.
    exp_disp.push_back(32'h1234_5678);
    mem[5] = 32'h1234_5678;
    drain("refresh", 18);
    check("refresh_disp", bus.disp_data, 32'h1234_5678);

    exp_disp.push_back(32'h0534_5678);
    show_idx = 1'b1;
    tick();
    check("overlay_disp", bus.disp_data, 32'h0534_5678);
    drain("overlay", 4);
    exp_disp.push_back(32'h1234_5678);
    show_idx = 1'b0;
    tick();
    drain("overlay_off", 4);

    // next then prev one cycle apart: the read of reg 6 is aborted and never shown.
    exp_idx.push_back(5'd6);
    exp_idx.push_back(5'd5);
    btn_next = 1'b1;
    tick();
    btn_prev = 1'b1;
    repeat (12) tick();
    btn_next = 1'b0;
    btn_prev = 1'b0;
    repeat (20) tick();
    drain("stale", 5);
    check("stale_disp", bus.disp_data, 32'h1234_5678);

    // Reset during WAIT: hold clears at once, then register 0 is re-read.
    exp_idx.push_back(5'd6);
    exp_idx.push_back(5'd0);
    exp_disp.push_back(32'h0);
    exp_disp.push_back(32'hA000_0000);
    btn_next = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (bus.rf_raddr == 5'd6) found = 1'b1;
    end
    check("wait_entered", {31'd0, found}, 32'd1);
    btn_next = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_wait_disp", bus.disp_data, 32'h0);
    drain("rst_wait", 10);
    check("rst_wait_reread", bus.disp_data, 32'hA000_0000);
    repeat (20) tick();
    check("leftover", exp_disp.size() + exp_idx.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
